// File: rtl/delay_commutator_stage4.sv
// Delay-commutator between radix-2 MDC butterfly stages 4 and 5 (32-point FFT).
// Lower stream is delayed DEPTH samples, the pair is swapped/passed on a
// per-sample counter, then the switched upper stream is delayed DEPTH samples
// so that samples DEPTH apart in each input stream leave as a pair.
module delay_commutator_stage4 #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic                    bypass,
  input  logic signed [WIDTH-1:0] inUI_re,
  input  logic signed [WIDTH-1:0] inUI_im,
  input  logic signed [WIDTH-1:0] inLI_re,
  input  logic signed [WIDTH-1:0] inLI_im,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    com_flag,
  output logic signed [WIDTH-1:0] Up_out_re,
  output logic signed [WIDTH-1:0] Up_out_im,
  output logic signed [WIDTH-1:0] Low_out_re,
  output logic signed [WIDTH-1:0] Low_out_im
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam int EW = 2 * WIDTH;        // one complex sample {re, im}
  localparam int LW = DEPTH * EW;       // one delay line, newest entry in the low bits
  localparam logic [CW-1:0] HALF = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d, k_cnt;
  logic          primed_q, primed_d;
  logic          swap;
  logic          com_flag_q;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic [LW-1:0] ld_q, ud_q;
  logic [EW-1:0] u_e, l_e, ld_old, ud_old, p_e, q_e;
  logic [EW-1:0] up_q, up_d, low_q, low_d;

  // Sample index, switch routing, priming and next output values for this sample
  always_comb begin
    k_cnt    = in_sof ? '0 : cnt_q;
    cnt_d    = k_cnt + CW'(1);
    // 2*DEPTH is a power of two, so cnt >= DEPTH is just the counter MSB
    swap     = k_cnt[CW-1];
    u_e      = {inUI_re, inUI_im};
    l_e      = {inLI_re, inLI_im};
    ld_old   = ld_q[LW-1 -: EW];
    ud_old   = ud_q[LW-1 -: EW];
    p_e      = swap ? ld_old : u_e;
    q_e      = swap ? u_e : ld_old;
    primed_d = (primed_q & ~in_sof) | (k_cnt == HALF);
    if (bypass) begin
      up_d        = u_e;
      low_d       = l_e;
      out_valid_d = 1'b1;
      out_sof_d   = in_sof;
    end else begin
      up_d        = ud_old;
      low_d       = q_e;
      out_valid_d = primed_d;
      out_sof_d   = (k_cnt == HALF) & ~(primed_q & ~in_sof);
    end
  end

  // State advances only on accepted samples; valid/sof strobes drop in gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      com_flag_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      ld_q        <= '0;
      ud_q        <= '0;
      up_q        <= '0;
      low_q       <= '0;
    end else if (in_valid) begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      com_flag_q  <= ~swap;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      // shift by truncating the concatenation: the oldest entry falls off the top
      ld_q        <= LW'({ld_q, l_e});
      ud_q        <= LW'({ud_q, p_e});
      up_q        <= up_d;
      low_q       <= low_d;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign com_flag   = com_flag_q;
  assign Up_out_re  = up_q[EW-1:WIDTH];
  assign Up_out_im  = up_q[WIDTH-1:0];
  assign Low_out_re = low_q[EW-1:WIDTH];
  assign Low_out_im = low_q[WIDTH-1:0];

endmodule

// File: tb/tb_delay_commutator_stage4.sv
// Directed bench for delay_commutator_stage4: DEPTH=2 and DEPTH=1 instances
// share the input stimulus. Imaginary parts are always driven as ~re, so the
// expected imaginary output of a pair is ~(expected real output).
module tb_delay_commutator_stage4;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof, bypass;
  logic signed [W-1:0] ui_re, ui_im, li_re, li_im;

  logic d2_valid, d2_sof, d2_flag;
  logic signed [W-1:0] d2_up_re, d2_up_im, d2_lo_re, d2_lo_im;
  logic d1_valid, d1_sof, d1_flag;
  logic signed [W-1:0] d1_up_re, d1_up_im, d1_lo_re, d1_lo_im;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit v; bit s; bit b; int u; int l;
    bit c; bit ev; bit es; bit ef; int eu; int el;
  } vec_t;

  vec_t tbl[$];
  vec_t seq_a[$];

  int a1[5]  = '{10, 11, 12, 13, 14};
  int b1[5]  = '{-10, -11, -12, -13, -14};
  int e1v[5] = '{0, 1, 1, 1, 1};
  int e1s[5] = '{0, 1, 0, 0, 0};
  int e1f[5] = '{1, 0, 1, 0, 1};
  int e1u[5] = '{0, 10, -10, 12, -12};
  int e1l[5] = '{0, 11, -11, 13, -13};

  always #5 clk = ~clk;

  delay_commutator_stage4 #(.WIDTH(W), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .bypass(bypass),
    .inUI_re(ui_re), .inUI_im(ui_im), .inLI_re(li_re), .inLI_im(li_im),
    .out_valid(d2_valid), .out_sof(d2_sof), .com_flag(d2_flag),
    .Up_out_re(d2_up_re), .Up_out_im(d2_up_im),
    .Low_out_re(d2_lo_re), .Low_out_im(d2_lo_im)
  );

  delay_commutator_stage4 #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .bypass(bypass),
    .inUI_re(ui_re), .inUI_im(ui_im), .inLI_re(li_re), .inLI_im(li_im),
    .out_valid(d1_valid), .out_sof(d1_sof), .com_flag(d1_flag),
    .Up_out_re(d1_up_re), .Up_out_im(d1_up_im),
    .Low_out_re(d1_lo_re), .Low_out_im(d1_lo_im)
  );

  function automatic vec_t V(bit v, bit s, bit b, int u, int l,
                             bit c, bit ev, bit es, bit ef, int eu, int el);
    vec_t t;
    t.v = v; t.s = s; t.b = b; t.u = u; t.l = l;
    t.c = c; t.ev = ev; t.es = es; t.ef = ef; t.eu = eu; t.el = el;
    return t;
  endfunction

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, bit s, bit b, int u, int l);
    in_valid = v;
    in_sof   = s;
    bypass   = b;
    ui_re    = W'(u);
    ui_im    = ~W'(u);
    li_re    = W'(l);
    li_im    = ~W'(l);
  endtask

  // One cycle on the table: drive at negedge, check 1 time unit after posedge
  task automatic run_vec(string tag, vec_t t);
    @(negedge clk);
    drive(t.v, t.s, t.b, t.u, t.l);
    @(posedge clk);
    #1;
    chk({tag, " valid"}, d2_valid, t.ev);
    chk({tag, " sof"}, d2_sof, t.es);
    chk({tag, " flag"}, d2_flag, t.ef);
    if (t.c) begin
      chk({tag, " up_re"}, d2_up_re, t.eu);
      chk({tag, " up_im"}, d2_up_im, -t.eu - 1);
      chk({tag, " lo_re"}, d2_lo_re, t.el);
      chk({tag, " lo_im"}, d2_lo_im, -t.el - 1);
    end
  endtask

  initial begin
    vec_t g;

    // continuous DEPTH=2 stream, sof at k=0; k=8,9 flush the last group
    seq_a.push_back(V(1,1,0,  1,  -1, 0,0,0,1,  0,  0));
    seq_a.push_back(V(1,0,0,  2,  -2, 0,0,0,1,  0,  0));
    seq_a.push_back(V(1,0,0,  3,  -3, 1,1,1,0,  1,  3));
    seq_a.push_back(V(1,0,0,  4,  -4, 1,1,0,0,  2,  4));
    seq_a.push_back(V(1,0,0,  5,  -5, 1,1,0,1, -1, -3));
    seq_a.push_back(V(1,0,0,  6,  -6, 1,1,0,1, -2, -4));
    seq_a.push_back(V(1,0,0,  7,  -7, 1,1,0,0,  5,  7));
    seq_a.push_back(V(1,0,0,  8,  -8, 1,1,0,0,  6,  8));
    seq_a.push_back(V(1,0,0,  9,  -9, 1,1,0,1, -5, -7));
    seq_a.push_back(V(1,0,0, 10, -10, 1,1,0,1, -6, -8));
    foreach (seq_a[i]) tbl.push_back(seq_a[i]);

    // same stream with a gap after every sample; gaps carry junk data and a
    // stray sof, outputs must hold and out_valid must drop
    foreach (seq_a[i]) begin
      tbl.push_back(seq_a[i]);
      g = seq_a[i];
      g.v = 0; g.s = 1; g.u = 99; g.l = -99; g.ev = 0; g.es = 0;
      tbl.push_back(g);
    end

    // sof re-asserted at k=5
    tbl.push_back(V(1,1,0,  1,  -1, 0,0,0,1,  0,  0));
    tbl.push_back(V(1,0,0,  2,  -2, 0,0,0,1,  0,  0));
    tbl.push_back(V(1,0,0,  3,  -3, 1,1,1,0,  1,  3));
    tbl.push_back(V(1,0,0,  4,  -4, 1,1,0,0,  2,  4));
    tbl.push_back(V(1,0,0,  5,  -5, 1,1,0,1, -1, -3));
    tbl.push_back(V(1,1,0,  6,  -6, 0,0,0,1,  0,  0));
    tbl.push_back(V(1,0,0,  7,  -7, 0,0,0,1,  0,  0));
    tbl.push_back(V(1,0,0,  8,  -8, 1,1,1,0,  6,  8));
    tbl.push_back(V(1,0,0,  9,  -9, 1,1,0,0,  7,  9));
    tbl.push_back(V(1,0,0, 10, -10, 1,1,0,1, -6, -8));
    tbl.push_back(V(1,0,0, 11, -11, 1,1,0,1, -7, -9));

    // bypass with full-scale values, counter still running underneath
    tbl.push_back(V(1,1,1, -256,  255, 1,1,1,1, -256,  255));
    tbl.push_back(V(1,0,1, -256,  255, 1,1,0,1, -256,  255));
    tbl.push_back(V(0,0,1,    7,    7, 1,0,0,1, -256,  255));
    tbl.push_back(V(1,0,1,  255, -256, 1,1,0,0,  255, -256));

    // asynchronous reset at time zero
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst0 valid", d2_valid, 0);
    chk("rst0 sof", d2_sof, 0);
    chk("rst0 flag", d2_flag, 1);
    chk("rst0 up_re", d2_up_re, 0);
    chk("rst0 lo_im", d2_lo_im, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // mid-stream reset with random data in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 0, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rstm valid", d2_valid, 0);
    chk("rstm sof", d2_sof, 0);
    chk("rstm flag", d2_flag, 1);
    chk("rstm up_re", d2_up_re, 0);
    chk("rstm up_im", d2_up_im, 0);
    chk("rstm lo_re", d2_lo_re, 0);
    chk("rstm lo_im", d2_lo_im, 0);
    chk("rstm d1 flag", d1_flag, 1);
    chk("rstm d1 valid", d1_valid, 0);

    // first samples after reset without sof start at cnt=0
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 20, -20);
    @(posedge clk); #1;
    chk("post k0 valid", d2_valid, 0);
    chk("post k0 flag", d2_flag, 1);
    chk("post k0 d1 valid", d1_valid, 0);
    @(negedge clk);
    drive(1, 0, 0, 21, -21);
    @(posedge clk); #1;
    chk("post k1 valid", d2_valid, 0);
    chk("post k1 flag", d2_flag, 1);
    chk("post k1 d1 valid", d1_valid, 1);
    chk("post k1 d1 flag", d1_flag, 0);
    chk("post k1 d1 up", d1_up_re, 20);
    chk("post k1 d1 lo", d1_lo_re, 21);
    @(negedge clk);
    drive(1, 0, 0, 22, -22);
    @(posedge clk); #1;
    chk("post k2 valid", d2_valid, 1);
    chk("post k2 flag", d2_flag, 0);
    chk("post k2 up", d2_up_re, 20);
    chk("post k2 lo", d2_lo_re, 22);
    chk("post k2 d1 flag", d1_flag, 1);
    chk("post k2 d1 up", d1_up_re, -20);
    chk("post k2 d1 lo", d1_lo_re, -21);

    // DEPTH=1 pairing: (a0,a1) (b0,b1) (a2,a3) (b2,b3)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, i == 0, 0, a1[i], b1[i]);
      @(posedge clk); #1;
      chk($sformatf("d1 k%0d valid", i), d1_valid, e1v[i]);
      chk($sformatf("d1 k%0d sof", i), d1_sof, e1s[i]);
      chk($sformatf("d1 k%0d flag", i), d1_flag, e1f[i]);
      if (e1v[i] != 0) begin
        chk($sformatf("d1 k%0d up_re", i), d1_up_re, e1u[i]);
        chk($sformatf("d1 k%0d up_im", i), d1_up_im, -e1u[i] - 1);
        chk($sformatf("d1 k%0d lo_re", i), d1_lo_re, e1l[i]);
        chk($sformatf("d1 k%0d lo_im", i), d1_lo_im, -e1l[i] - 1);
      end
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
